// File: rtl/serial_pkg.sv
// Shared types and constants for the chip-select serial transmitter.
// Holds the FSM encoding, the shift-order mode values and a counter-width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int MODE_LSB_FIRST = 1;
  localparam int MODE_MSB_FIRST = 0;

  // Counter wide enough to hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_half_tick.sv
// Divides sys_clk by CLK_DIV: tick_o pulses for one cycle every CLK_DIV cycles while en_i is high.
// The first tick comes CLK_DIV cycles after enable rises; dropping en_i restarts the count.
module serial_half_tick
  import serial_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int DIV_W = cnt_w(CLK_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx_cs.sv
// Parallel-to-serial transmitter with cs framing (SPI mode 0); a frame keeps cs low for DATA_W*2*CLK_DIV + CS_HOLD*CLK_DIV cycles.
// One word is accepted per frame via start/ready; start while busy is ignored, not queued.
module serial_tx_cs
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int LSB_FIRST = 1,
  parameter int CS_HOLD   = 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready,
  output logic              data_o,
  output logic              sclk,
  output logic              cs,
  output logic              done
);

  localparam int BIT_W    = cnt_w(DATA_W);
  localparam int HOLD_CYC = CS_HOLD * CLK_DIV;
  localparam int HOLD_W   = cnt_w(HOLD_CYC);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BIT_W-1:0]  bit_q, bit_d, bit_nxt;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              dat_q, dat_d;
  logic              done_q, done_d;
  logic              rdy_q, rdy_d;
  logic              half_tick;

  serial_half_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_half_tick (
    .sys_clk(sys_clk),
    .rst    (rst),
    .en_i   (state_q == ST_SHIFT),
    .tick_o (half_tick)
  );

  assign bit_nxt = bit_q + BIT_W'(1);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    dat_d   = dat_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = data_i;
          cs_d    = 1'b0;
          rdy_d   = 1'b0;
          sclk_d  = 1'b0;
          bit_d   = '0;
          hold_d  = '0;
          dat_d   = (LSB_FIRST == MODE_LSB_FIRST) ? data_i[0] : data_i[DATA_W-1];
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (half_tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of a bit period: the falling edge moves data_o to the next bit.
            sclk_d = 1'b0;
            if (bit_nxt == BIT_W'(DATA_W)) begin
              bit_d   = '0;
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_nxt;
              if (LSB_FIRST == MODE_LSB_FIRST) begin
                sr_d  = sr_q >> 1;
                dat_d = sr_q[1];
              end else begin
                sr_d  = sr_q << 1;
                dat_d = sr_q[DATA_W-2];
              end
            end
          end
        end
      end

      ST_HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
          hold_d  = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
          dat_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      dat_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign ready  = rdy_q;
  assign data_o = dat_q;
  assign sclk   = sclk_q;
  assign cs     = cs_q;
  assign done   = done_q;

endmodule
